mem_access_ctrl: RTL and testbench

Memory-stage access controller sitting on the consumer side of the EX/MEM pipeline latch. It turns the latched dREN/dWEN/address/store-data fields into a single, non-repeating request to the data cache, waits for dhit, holds the returned load word until the pipeline advances, and produces the advance-permission signal that drives the en inputs of the pipeline latches. It also turns a latched halt into a sticky processor halt once memory traffic has drained, and keeps saturating load/store counters for debug.

---
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one non-repeating data cache request
// per instruction sitting in the EX/MEM latch, holds the returned load word
// until the pipeline advances, drives the pipeline advance enable, converts a
// drained halt into a sticky processor halt and keeps saturating debug counts.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access outstanding; a new request is issued combinationally
// REQ    | request held to the cache, waiting for dhit_i
// DONE   | access completed, waiting for the pipeline to advance
// HALTED | processor halted, all traffic stopped until reset
module mem_access_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_i,
  input  logic        halt_i,
  input  logic        ihit_i,
  input  logic        dhit_i,
  input  logic [31:0] dmemload_i,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [31:0] load_o,
  output logic        pipe_en,
  output logic        halt,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;

  logic mem_op;
  logic req_phase;
  logic acc_done;
  logic leave_ok;
  logic unused_addr_lsb;

  // Request qualification shared by outputs, next-state and counters.
  always_comb begin
    mem_op    = dREN_i | dWEN_i;
    req_phase = (state_q == IDLE) || (state_q == REQ);
    acc_done  = req_phase & mem_op & dhit_i;
  end

  // Cache request, advance permission and load data steering.
  always_comb begin
    dmemREN   = req_phase & dREN_i & ~dWEN_i;
    dmemWEN   = req_phase & dWEN_i;
    dmemaddr  = {addr_i[31:2], 2'b00};
    dmemstore = store_i;
    load_o    = (state_q == DONE) ? hold_q : dmemload_i;
    pipe_en   = ihit_i & (~mem_op | dhit_i | (state_q == DONE))
                & (state_q != HALTED) & ~halt_i;
    halt      = (state_q == HALTED);
    load_cnt  = load_cnt_q;
    store_cnt = store_cnt_q;
  end

  // Byte offset is dropped: the cache is word addressed.
  assign unused_addr_lsb = ^addr_i[1:0];

  // A pending halt blocks pipe_en, so it also releases a finished access
  // back to IDLE; otherwise the access could never retire and the halt
  // would never be reconsidered.
  assign leave_ok = pipe_en | halt_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (halt_i && !mem_op) begin
          state_d = HALTED;
        end else if (mem_op) begin
          if (dhit_i) state_d = leave_ok ? IDLE : DONE;
          else        state_d = REQ;
        end
      end
      REQ: begin
        if (dhit_i) state_d = leave_ok ? IDLE : DONE;
      end
      DONE: begin
        if (leave_ok) state_d = IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Load capture and saturating completion counters.
  always_comb begin
    hold_d      = hold_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (acc_done) begin
      hold_d = dmemload_i;
      if (dWEN_i) begin
        if (store_cnt_q != 16'hFFFF) store_cnt_d = store_cnt_q + 16'd1;
      end else begin
        if (load_cnt_q != 16'hFFFF) load_cnt_d = load_cnt_q + 16'd1;
      end
    end
  end

  // State and data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      hold_q      <= 32'h0;
      load_cnt_q  <= 16'h0;
      store_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard for completed accesses.
module tb_mem_access_ctrl;

  logic        CLK, nRST;
  logic        dREN_i, dWEN_i, halt_i, ihit_i, dhit_i;
  logic [31:0] addr_i, store_i, dmemload_i;
  logic        dmemREN, dmemWEN, pipe_en, halt;
  logic [31:0] dmemaddr, dmemstore, load_o;
  logic [15:0] load_cnt, store_cnt;

  mem_access_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_i(dREN_i), .dWEN_i(dWEN_i), .addr_i(addr_i), .store_i(store_i),
    .halt_i(halt_i), .ihit_i(ihit_i), .dhit_i(dhit_i), .dmemload_i(dmemload_i),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .load_o(load_o), .pipe_en(pipe_en), .halt(halt),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic sb_en = 1'b1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_wr = wr;
    e.addr  = a;
    e.data  = d;
    sb_q.push_back(e);
  endtask

  // Monitor: every access completion presented by the DUT is matched against
  // the next expected transaction.
  always @(negedge CLK) begin
    if (sb_en && nRST && dhit_i && (dmemREN || dmemWEN)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got access addr %h wen %b with nothing expected", dmemaddr, dmemWEN);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_wen",  {31'h0, dmemWEN}, {31'h0, mon_e.is_wr});
        check("sb_ren",  {31'h0, dmemREN}, {31'h0, ~mon_e.is_wr});
        check("sb_addr", dmemaddr, mon_e.addr);
        if (mon_e.is_wr) check("sb_store", dmemstore, mon_e.data);
        else             check("sb_load",  load_o,    mon_e.data);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    dREN_i = 0; dWEN_i = 0; halt_i = 0; ihit_i = 0; dhit_i = 0;
    addr_i = 0; store_i = 0; dmemload_i = 0;

    // Reset state
    @(negedge CLK);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_lcnt", {16'h0, load_cnt}, 32'h0);
    check("rst_scnt", {16'h0, store_cnt}, 32'h0);
    check("rst_pipe", {31'h0, pipe_en}, 32'h0);
    check("rst_ren",  {31'h0, dmemREN}, 32'h0);
    check("rst_wen",  {31'h0, dmemWEN}, 32'h0);
    next_cyc;
    nRST = 1'b1;
    next_cyc;

    // Load, dhit on third request cycle
    addr_i = 32'h0000_0106; dREN_i = 1; ihit_i = 1; dmemload_i = 32'hDEAD_BEEF;
    push(1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dhit_i = 1;
      @(negedge CLK);
      check("ld_ren",  {31'h0, dmemREN}, 32'h1);
      check("ld_addr", dmemaddr, 32'h0000_0104);
      check("ld_pipe", {31'h0, pipe_en}, (i == 2) ? 32'h1 : 32'h0);
      next_cyc;
    end
    dREN_i = 0; dhit_i = 0;
    @(negedge CLK);
    check("ld_ren_off", {31'h0, dmemREN}, 32'h0);
    check("ld_cnt", {16'h0, load_cnt}, 32'h1);
    next_cyc;

    // Store, dhit while fetch stalls for two cycles
    ihit_i = 0; dWEN_i = 1; store_i = 32'h1234_5678; addr_i = 32'h0000_0208;
    push(1'b1, 32'h0000_0208, 32'h1234_5678);
    @(negedge CLK);
    check("st_wen0", {31'h0, dmemWEN}, 32'h1);
    check("st_store", dmemstore, 32'h1234_5678);
    next_cyc;
    dhit_i = 1;
    @(negedge CLK);
    check("st_wen1", {31'h0, dmemWEN}, 32'h1);
    check("st_pipe1", {31'h0, pipe_en}, 32'h0);
    next_cyc;
    dhit_i = 0;
    for (int i = 0; i < 2; i++) begin
      dhit_i = (i == 1);
      @(negedge CLK);
      check("st_done_wen", {31'h0, dmemWEN}, 32'h0);
      check("st_done_pipe", {31'h0, pipe_en}, 32'h0);
      next_cyc;
    end
    dhit_i = 0; ihit_i = 1;
    @(negedge CLK);
    check("st_adv_pipe", {31'h0, pipe_en}, 32'h1);
    check("st_adv_wen", {31'h0, dmemWEN}, 32'h0);
    next_cyc;
    dWEN_i = 0; ihit_i = 0;
    @(negedge CLK);
    check("st_cnt", {16'h0, store_cnt}, 32'h1);
    check("st_lcnt", {16'h0, load_cnt}, 32'h1);
    next_cyc;

    // Load with immediate dhit but no ihit: load word must be held in DONE
    dREN_i = 1; addr_i = 32'h0000_0020; dhit_i = 1; dmemload_i = 32'hA5A5_5A5A;
    push(1'b0, 32'h0000_0020, 32'hA5A5_5A5A);
    next_cyc;
    dhit_i = 0; dmemload_i = 32'h0;
    @(negedge CLK);
    check("hold_load", load_o, 32'hA5A5_5A5A);
    check("hold_ren", {31'h0, dmemREN}, 32'h0);
    next_cyc;
    ihit_i = 1;
    @(negedge CLK);
    check("hold_adv", {31'h0, pipe_en}, 32'h1);
    check("hold_load2", load_o, 32'hA5A5_5A5A);
    next_cyc;
    dREN_i = 0;
    @(negedge CLK);
    check("hold_cnt", {16'h0, load_cnt}, 32'h2);
    next_cyc;

    // Both read and write requested: store wins
    dREN_i = 1; dWEN_i = 1; addr_i = 32'h0000_040C; store_i = 32'hFEED_FACE; dhit_i = 1;
    push(1'b1, 32'h0000_040C, 32'hFEED_FACE);
    @(negedge CLK);
    check("both_wen", {31'h0, dmemWEN}, 32'h1);
    check("both_ren", {31'h0, dmemREN}, 32'h0);
    check("both_pipe", {31'h0, pipe_en}, 32'h1);
    next_cyc;
    dREN_i = 0; dWEN_i = 0; dhit_i = 0;
    @(negedge CLK);
    check("both_scnt", {16'h0, store_cnt}, 32'h2);
    check("both_lcnt", {16'h0, load_cnt}, 32'h2);
    next_cyc;

    // Halt behind an outstanding load
    dREN_i = 1; halt_i = 1; addr_i = 32'h0000_0310; dmemload_i = 32'hCAFE_F00D;
    push(1'b0, 32'h0000_0310, 32'hCAFE_F00D);
    @(negedge CLK);
    check("hlt_ren0", {31'h0, dmemREN}, 32'h1);
    check("hlt_pipe0", {31'h0, pipe_en}, 32'h0);
    check("hlt_h0", {31'h0, halt}, 32'h0);
    next_cyc;
    dhit_i = 1;
    @(negedge CLK);
    check("hlt_ren1", {31'h0, dmemREN}, 32'h1);
    check("hlt_h1", {31'h0, halt}, 32'h0);
    next_cyc;
    dREN_i = 0; dhit_i = 0;
    @(negedge CLK);
    check("hlt_h2", {31'h0, halt}, 32'h0);
    check("hlt_lcnt", {16'h0, load_cnt}, 32'h3);
    next_cyc;
    @(negedge CLK);
    check("hlt_h3", {31'h0, halt}, 32'h1);
    check("hlt_pipe3", {31'h0, pipe_en}, 32'h0);
    next_cyc;
    dREN_i = 1; dWEN_i = 1; dhit_i = 1; halt_i = 0;
    @(negedge CLK);
    check("hlt_abs_ren", {31'h0, dmemREN}, 32'h0);
    check("hlt_abs_wen", {31'h0, dmemWEN}, 32'h0);
    check("hlt_abs_pipe", {31'h0, pipe_en}, 32'h0);
    check("hlt_abs_h", {31'h0, halt}, 32'h1);
    next_cyc;

    // Reset out of HALTED
    dREN_i = 0; dWEN_i = 0; dhit_i = 0; nRST = 0;
    #1;
    check("rst2_halt", {31'h0, halt}, 32'h0);
    check("rst2_scnt", {16'h0, store_cnt}, 32'h0);
    next_cyc;
    nRST = 1;
    next_cyc;

    // Saturation: preload 0xFFFF single-cycle loads
    sb_en = 0;
    dREN_i = 1; ihit_i = 1; dhit_i = 1; addr_i = 32'h0000_0800; dmemload_i = 32'h1;
    repeat (65535) next_cyc;
    check("sat_pre", {16'h0, load_cnt}, 32'h0000_FFFF);
    sb_en = 1;
    push(1'b0, 32'h0000_0800, 32'h1);
    next_cyc;
    check("sat_post", {16'h0, load_cnt}, 32'h0000_FFFF);
    check("sat_scnt", {16'h0, store_cnt}, 32'h0);
    dREN_i = 0; dhit_i = 0;
    next_cyc;

    // Reset asserted while the request is outstanding
    dREN_i = 1; addr_i = 32'h0000_0500;
    next_cyc;
    @(negedge CLK);
    check("rreq_ren", {31'h0, dmemREN}, 32'h1);
    check("rreq_pipe", {31'h0, pipe_en}, 32'h0);
    #2;
    nRST = 0; dREN_i = 0;
    #1;
    check("rreq_ren_off", {31'h0, dmemREN}, 32'h0);
    check("rreq_lcnt", {16'h0, load_cnt}, 32'h0);
    check("rreq_halt", {31'h0, halt}, 32'h0);
    next_cyc;
    nRST = 1;
    @(negedge CLK);
    check("rreq_rel_ren", {31'h0, dmemREN}, 32'h0);
    check("rreq_rel_halt", {31'h0, halt}, 32'h0);
    next_cyc;
    dREN_i = 1; dhit_i = 1; addr_i = 32'h0000_0504; dmemload_i = 32'h0BAD_CAFE;
    push(1'b0, 32'h0000_0504, 32'h0BAD_CAFE);
    @(negedge CLK);
    check("rreq_new_pipe", {31'h0, pipe_en}, 32'h1);
    next_cyc;
    dREN_i = 0; dhit_i = 0;
    @(negedge CLK);
    check("rreq_new_cnt", {16'h0, load_cnt}, 32'h1);
    next_cyc;

    check("sb_drained", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
